// File: rtl/dispense_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : dispense_pkg                                             |
// | Description : Shared types and constants for the dispense subsystem:   |
// |               step-generator state codes, dispense-controller state    |
// |               codes, default step rate/timing constants and a helper   |
// |               that sizes the step period timer.                        |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package dispense_pkg;

  // Default step timing at a 12 MHz system clock.
  localparam int unsigned STEP_CLK_FREQ   = 12_000_000;
  localparam int unsigned STEP_SLOW_HZ    = 1_000;
  localparam int unsigned STEP_FAST_HZ    = 2_000;
  localparam int unsigned STEP_PULSE_HIGH = 120;
  localparam int unsigned STEP_DIR_SETUP  = 60;

  // Step generator states.
  typedef enum logic [2:0] {
    STEP_IDLE  = 3'd0,
    STEP_SETUP = 3'd1,
    STEP_HIGH  = 3'd2,
    STEP_LOW   = 3'd3,
    STEP_DONE  = 3'd4
  } step_state_t;

  // Dispense controller states.
  typedef enum logic [2:0] {
    CTRL_IDLE     = 3'd0,
    CTRL_HOME     = 3'd1,
    CTRL_DISPENSE = 3'd2,
    CTRL_RETRACT  = 3'd3,
    CTRL_FAULT    = 3'd4
  } ctrl_state_t;

  // Bits needed to hold a timer load of (max_period - 1); the longest
  // period is one full slow step, so this covers every phase.
  function automatic int unsigned timer_width(input int unsigned max_period);
    return $clog2(max_period);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stepper_step_gen_cycle_timer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : cycle_timer                                              |
// | Description : Loadable down-counter with a zero flag. Loading N-1      |
// |               makes zero assert in the Nth cycle after the load edge,  |
// |               so a state that loads on entry lasts exactly N cycles.   |
// | Ports       : clk, rst (async, active-high), load, load_value[W],      |
// |               zero (count has reached 0).                              |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module cycle_timer #(
  parameter int unsigned WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/stepper_step_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : stepper_step_gen                                         |
// | Description : STEP/DIR pulse generator for a stepper driver. A start   |
// |               request latches direction, rate and step count, waits    |
// |               a direction setup time, then issues the requested        |
// |               number of fixed-width STEP pulses at the selected rate.  |
// | Ports       : clk, rst (async, active-high)                            |
// |               start, dir_in, speed_fast, step_count[10], abort         |
// |               busy, done, step_out, dir_out, steps_issued[10]          |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module stepper_step_gen
  import dispense_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = STEP_CLK_FREQ,
  parameter int unsigned SLOW_HZ    = STEP_SLOW_HZ,
  parameter int unsigned FAST_HZ    = STEP_FAST_HZ,
  parameter int unsigned PULSE_HIGH = STEP_PULSE_HIGH,
  parameter int unsigned DIR_SETUP  = STEP_DIR_SETUP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dir_in,
  input  logic       speed_fast,
  input  logic [9:0] step_count,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       step_out,
  output logic       dir_out,
  output logic [9:0] steps_issued
);

  localparam int unsigned TW = timer_width(CLK_FREQ / SLOW_HZ);

  // Timer loads are (phase length - 1); all divisions fold at elaboration.
  localparam logic [TW-1:0] C_SETUP_LOAD    = TW'(DIR_SETUP - 1);
  localparam logic [TW-1:0] C_HIGH_LOAD     = TW'(PULSE_HIGH - 1);
  localparam logic [TW-1:0] C_LOW_SLOW_LOAD = TW'(CLK_FREQ / SLOW_HZ - PULSE_HIGH - 1);
  localparam logic [TW-1:0] C_LOW_FAST_LOAD = TW'(CLK_FREQ / FAST_HZ - PULSE_HIGH - 1);

  step_state_t   r_state;
  step_state_t   w_next;
  logic          r_fast;
  logic [9:0]    r_count;
  logic          w_load;
  logic [TW-1:0] w_load_value;
  logic          w_zero;
  logic          w_accept;

  cycle_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (w_load),
    .load_value (w_load_value),
    .zero       (w_zero)
  );

  assign w_accept = (r_state == STEP_IDLE) && start && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= STEP_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and timer load. Abort takes priority over timer expiry.
  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_load_value = '0;
    case (r_state)
      STEP_IDLE: begin
        if (w_accept) begin
          if (step_count == '0) begin
            w_next = STEP_DONE;
          end else begin
            w_next       = STEP_SETUP;
            w_load       = 1'b1;
            w_load_value = C_SETUP_LOAD;
          end
        end
      end
      STEP_SETUP: begin
        if (abort) begin
          w_next = STEP_DONE;
        end else if (w_zero) begin
          w_next       = STEP_HIGH;
          w_load       = 1'b1;
          w_load_value = C_HIGH_LOAD;
        end
      end
      STEP_HIGH: begin
        if (abort) begin
          w_next = STEP_DONE;
        end else if (w_zero) begin
          w_next       = STEP_LOW;
          w_load       = 1'b1;
          w_load_value = r_fast ? C_LOW_FAST_LOAD : C_LOW_SLOW_LOAD;
        end
      end
      STEP_LOW: begin
        if (abort) begin
          w_next = STEP_DONE;
        end else if (w_zero) begin
          if (steps_issued < r_count) begin
            w_next       = STEP_HIGH;
            w_load       = 1'b1;
            w_load_value = C_HIGH_LOAD;
          end else begin
            w_next = STEP_DONE;
          end
        end
      end
      STEP_DONE: begin
        w_next = STEP_IDLE;
      end
      default: begin
        w_next = STEP_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fast       <= 1'b0;
      r_count      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      step_out     <= 1'b0;
      dir_out      <= 1'b0;
      steps_issued <= '0;
    end else begin
      step_out <= (w_next == STEP_HIGH);
      done     <= (w_next == STEP_DONE);
      busy     <= (w_next == STEP_SETUP) || (w_next == STEP_HIGH) ||
                  (w_next == STEP_LOW);
      if (w_accept) begin
        r_fast       <= speed_fast;
        r_count      <= step_count;
        steps_issued <= '0;
        // A zero-length move never drives the motor, so DIR stays put.
        if (step_count != '0) begin
          dir_out <= dir_in;
        end
      end else if ((w_next == STEP_HIGH) && (r_state != STEP_HIGH)) begin
        steps_issued <= steps_issued + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stepper_step_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_stepper_step_gen                                      |
// | Description : Self-checking bench for stepper_step_gen. A timeline     |
// |               model (time since start -> expected outputs) is checked  |
// |               every cycle; directed scenarios add literal timing pins. |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_stepper_step_gen;

  localparam int DS     = 60;
  localparam int PH     = 120;
  localparam int P_SLOW = 12_000_000 / 1000;
  localparam int P_FAST = 12_000_000 / 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dir_in;
  logic       speed_fast;
  logic [9:0] step_count;
  logic       abort;
  logic       busy;
  logic       done;
  logic       step_out;
  logic       dir_out;
  logic [9:0] steps_issued;

  stepper_step_gen dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .dir_in       (dir_in),
    .speed_fast   (speed_fast),
    .step_count   (step_count),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .step_out     (step_out),
    .dir_out      (dir_out),
    .steps_issued (steps_issued)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: a move is a timeline; t is the cycle index after acceptance
  // (t=1 is the first cycle after the accepting edge).
  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_DONE = 2;
  int   m_mode  = M_IDLE;
  int   m_t     = 0;
  int   m_n     = 0;
  int   m_p     = P_SLOW;
  int   m_steps = 0;
  logic m_dir   = 1'b0;

  // Observed edge/pulse history for literal timing checks.
  int   rises[$];
  int   falls[$];
  int   done_cnt  = 0;
  int   last_done = 0;
  logic prev_step = 1'b0;
  int   s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_mode = M_IDLE; m_t = 0; m_steps = 0; m_dir = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (start && !abort) begin
            m_steps = 0;
            if (step_count == 10'd0) begin
              m_mode = M_DONE;
            end else begin
              m_mode = M_MOVE;
              m_t    = 1;
              m_n    = int'(step_count);
              m_p    = speed_fast ? P_FAST : P_SLOW;
              m_dir  = dir_in;
            end
          end
        end
        M_MOVE: begin
          if (abort || (m_t == DS + m_n * m_p)) begin
            m_mode = M_DONE;
          end else begin
            m_t++;
            m_steps = (m_t <= DS) ? 0 : (m_t - DS - 1) / m_p + 1;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic compare();
    logic exp_step;
    exp_step = (m_mode == M_MOVE) && (m_t > DS) && (((m_t - DS - 1) % m_p) < PH);
    chk("busy",         busy,         m_mode == M_MOVE);
    chk("done",         done,         m_mode == M_DONE);
    chk("step_out",     step_out,     exp_step);
    chk("dir_out",      dir_out,      m_dir);
    chk("steps_issued", steps_issued, m_steps);
    if (step_out && !prev_step) rises.push_back(cyc);
    if (!step_out && prev_step) falls.push_back(cyc);
    if (done) begin done_cnt++; last_done = cyc; end
    prev_step = step_out;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_obs();
    rises.delete();
    falls.delete();
    done_cnt = 0;
  endtask

  // Start is high during cycle s; returns after the accepting edge.
  task automatic pulse_start(input logic d, input logic f, input logic [9:0] c);
    start = 1'b1; dir_in = d; speed_fast = f; step_count = c;
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    chk("rst_async_step", step_out, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_done", done, 0);
    chk("rst_async_dir", dir_out, 0);
    chk("rst_async_steps", steps_issued, 0);
    model_step();
    run(2);
    rst = 1'b0;
    prev_step = step_out;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    dir_in = 1'b0; speed_fast = 1'b0; step_count = '0;
    run(3);
    chk("reset_busy", busy, 0);
    chk("reset_step", step_out, 0);
    chk("reset_steps", steps_issued, 0);
    rst = 1'b0;
    run(2);

    // Zero-length move: done one cycle after start, no pulse, DIR unchanged.
    clear_obs();
    pulse_start(1'b1, 1'b1, 10'd0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_dir", dir_out, 0);
    run(3);
    chk("zero_rises", rises.size(), 0);
    chk("zero_done_cnt", done_cnt, 1);

    // Start together with abort in IDLE: nothing happens.
    clear_obs();
    start = 1'b1; abort = 1'b1; step_count = 10'd3; dir_in = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    run(200);
    chk("sa_busy", busy, 0);
    chk("sa_rises", rises.size(), 0);
    chk("sa_done_cnt", done_cnt, 0);

    // Reset in the middle of the first LOW: outputs clear, no done pulse.
    clear_obs();
    pulse_start(1'b1, 1'b1, 10'd5);
    run(499);
    chk("pre_rst_steps", steps_issued, 1);
    apply_reset();
    run(2);
    chk("rst_no_done", done_cnt, 0);

    // Three fast steps, direction 1.
    clear_obs();
    pulse_start(1'b1, 1'b1, 10'd3);
    chk("f3_dir_next", dir_out, 1);
    chk("f3_busy_next", busy, 1);
    run(18065);
    chk("f3_rises", rises.size(), 3);
    chk("f3_falls", falls.size(), 3);
    if (rises.size() == 3 && falls.size() == 3) begin
      chk("f3_rise0", rises[0] - s, 61);
      chk("f3_rise1", rises[1] - s, 6061);
      chk("f3_rise2", rises[2] - s, 12061);
      for (int i = 0; i < 3; i++) chk("f3_width", falls[i] - rises[i], PH);
    end
    chk("f3_done_cnt", done_cnt, 1);
    chk("f3_done_time", last_done - s, 18061);
    chk("f3_steps", steps_issued, 3);

    // Two slow steps while extra starts arrive during the move.
    clear_obs();
    pulse_start(1'b0, 1'b0, 10'd2);
    for (int i = 0; i < 24070; i++) begin
      dir_in     = 1'($urandom);
      speed_fast = 1'($urandom);
      step_count = 10'($urandom);
      start      = ($urandom_range(0, 99) == 0) && (cyc - s < 24000);
      tick();
    end
    start = 1'b0;
    chk("s2_rises", rises.size(), 2);
    if (rises.size() == 2) begin
      chk("s2_rise0", rises[0] - s, 61);
      chk("s2_period", rises[1] - rises[0], 12000);
    end
    chk("s2_steps", steps_issued, 2);
    chk("s2_done_cnt", done_cnt, 1);
    chk("s2_done_time", last_done - s, 24061);
    chk("s2_dir", dir_out, 0);

    // Abort during the second HIGH of a five-step move.
    clear_obs();
    pulse_start(1'b1, 1'b1, 10'd5);
    run(6099);
    chk("ab_in_high", step_out, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_step_low", step_out, 0);
    chk("ab_done", done, 1);
    chk("ab_steps", steps_issued, 2);
    chk("ab_busy", busy, 0);
    run(5);
    chk("ab_done_cnt", done_cnt, 1);
    chk("ab_steps_hold", steps_issued, 2);

    // Random traffic against the model.
    for (int i = 0; i < 20000; i++) begin
      start      = ($urandom_range(0, 299) == 0);
      abort      = ($urandom_range(0, 1999) == 0);
      dir_in     = 1'($urandom);
      speed_fast = 1'($urandom);
      step_count = ($urandom_range(0, 2) == 0) ? 10'($urandom_range(0, 2))
                                               : 10'($urandom_range(0, 1023));
      tick();
    end
    start = 1'b0; abort = 1'b0;
    run(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
